// File: rtl/receiving.sv
// ============================================================================
// Module   : receiving
// Brief    : 8N1 UART receiver with mid-bit sampling and frame-error strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module receiving #(
   parameter int F    = 8000000,
   parameter int BAUD = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV  = F / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] c_div_last  = CW'(DIV - 1);
   localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);
   localparam logic [CW-1:0] c_one       = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            w_rxs;

   assign w_rxs = r_sync2;
   assign busy  = (r_state != S_IDLE);

   // Synchroniser resets to the idle line level so reset never fakes a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= 3'd0;
         r_shift   <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_bit <= 3'd0;
               if (!w_rxs) r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == c_half_last) begin
                  r_cnt   <= '0;
                  r_state <= w_rxs ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            S_DATA: begin
               if (r_cnt == c_div_last) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rxs, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            S_STOP: begin
               if (r_cnt == c_div_last) begin
                  r_cnt <= '0;
                  if (w_rxs) begin
                     data    <= r_shift;
                     valid   <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     r_state   <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            S_BREAK: begin
               // Held-low line: stay here until it recovers so no repeated strobes.
               r_cnt <= '0;
               if (w_rxs) r_state <= S_IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
